// File: rtl/tag_free_list_arbiter_pkg.sv
// Shared types and constants for the tag free-list arbiter.
// reset_mask() builds the power-on free bitmap with the reserved tags removed.
package tag_free_list_arbiter_pkg;

    localparam int MAX_REQ      = 4;
    localparam int MAX_TAGS     = 256;
    localparam int DEF_NUM_TAGS = 16;
    localparam int DEF_TAG_W    = $clog2(DEF_NUM_TAGS);

    typedef logic [DEF_TAG_W-1:0] tag_t;

    function automatic logic [MAX_TAGS-1:0] reset_mask(input int num_tags, input int num_reserved);
        logic [MAX_TAGS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_TAGS; i++) begin
            if (i >= num_reserved && i < num_tags) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tag_free_list_arbiter_if.sv
// Allocation / release / status bundle between the free list and its clients.
// The free list is the slave side; requesters, commit and recovery form the master.
interface tag_free_list_arbiter_if #(
    parameter int NUM_TAGS = 16,
    parameter int NUM_REQ  = 2
);
    localparam int TAG_W = $clog2(NUM_TAGS);

    logic [NUM_REQ-1:0] alloc_valid_i;
    logic [NUM_REQ-1:0] alloc_ready_o;
    logic [TAG_W-1:0]   alloc_tag_o;
    logic               rel_valid_i;
    logic [TAG_W-1:0]   rel_tag_i;
    logic               flush_i;
    logic [TAG_W:0]     free_cnt_o;
    logic               empty_o;
    logic               err_o;

    modport slave (
        input  alloc_valid_i, rel_valid_i, rel_tag_i, flush_i,
        output alloc_ready_o, alloc_tag_o, free_cnt_o, empty_o, err_o
    );

    modport master (
        output alloc_valid_i, rel_valid_i, rel_tag_i, flush_i,
        input  alloc_ready_o, alloc_tag_o, free_cnt_o, empty_o, err_o
    );

endinterface

// File: rtl/tag_free_list_arbiter_lzc.sv
// Counts the run of COUNT_ZERO ? zeros : ones starting at bit 0.
// With COUNT_ZERO=1 this is the index of the lowest set bit, or DATA_WIDTH if none.
module leading_zero_one_cnt #(
    parameter int DATA_WIDTH = 16,
    parameter int COUNT_ZERO = 1,
    localparam int CNT_W     = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CNT_W-1:0]      cnt_o
);

    localparam logic STOP_BIT = (COUNT_ZERO != 0) ? 1'b1 : 1'b0;

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        cnt_o = CNT_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (data_i[i] == STOP_BIT) cnt_o = CNT_W'(i);
        end
    end

endmodule

// File: rtl/tag_free_list_arbiter.sv
// Bitmap free list of physical tags, granting the lowest free tag to one
// round-robin-selected requester per cycle, with release and flush paths.
module tag_free_list_arbiter
    import tag_free_list_arbiter_pkg::*;
#(
    parameter int  NUM_TAGS     = DEF_NUM_TAGS,
    parameter int  NUM_REQ      = 2,
    parameter int  NUM_RESERVED = 1,
    localparam int TAG_W        = $clog2(NUM_TAGS)
) (
    input logic                   clk,
    input logic                   rst_n,
    tag_free_list_arbiter_if.slave bus
);

    localparam int                  RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [MAX_TAGS-1:0] RST_FULL = reset_mask(NUM_TAGS, NUM_RESERVED);
    localparam logic [NUM_TAGS-1:0] RST_MAP  = RST_FULL[NUM_TAGS-1:0];
    localparam logic [TAG_W:0]      RST_CNT  = (TAG_W+1)'(NUM_TAGS - NUM_RESERVED);

    logic [NUM_TAGS-1:0] free_map_q, free_map_d;
    logic [TAG_W:0]      free_cnt_q, free_cnt_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic                err_q, err_d;

    logic [TAG_W:0]      lzc_cnt;
    logic                empty;
    logic [TAG_W-1:0]    alloc_tag;
    logic [RR_W-1:0]     winner;
    logic [RR_W-1:0]     winner_nxt;
    logic                winner_found;
    logic [NUM_REQ-1:0]  alloc_ready;
    logic                fire;
    logic                rel_bad;
    logic                rel_ok;
    logic                rel_err;

    leading_zero_one_cnt #(
        .DATA_WIDTH (NUM_TAGS),
        .COUNT_ZERO (1)
    ) u_lzc (
        .data_i (free_map_q),
        .cnt_o  (lzc_cnt)
    );

    assign empty     = lzc_cnt[TAG_W];
    assign alloc_tag = lzc_cnt[TAG_W-1:0];

    // Descending scan so the first valid requester at or after rr_q wins.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.alloc_valid_i[(int'(rr_q) + k) % NUM_REQ]) begin
                winner       = RR_W'((int'(rr_q) + k) % NUM_REQ);
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_ready = '0;
        if (winner_found && !empty && !bus.flush_i) alloc_ready[winner] = 1'b1;
    end

    assign fire       = |alloc_ready;
    assign winner_nxt = (int'(winner) == NUM_REQ - 1) ? '0 : winner + RR_W'(1);

    assign rel_bad = (int'(bus.rel_tag_i) < NUM_RESERVED) || free_map_q[bus.rel_tag_i];
    assign rel_ok  = bus.rel_valid_i && !bus.flush_i && !rel_bad;
    assign rel_err = bus.rel_valid_i && !bus.flush_i && rel_bad;

    always_comb begin
        free_map_d = free_map_q;
        free_cnt_d = free_cnt_q;
        rr_d       = rr_q;
        err_d      = err_q | rel_err;
        if (bus.flush_i) begin
            free_map_d = RST_MAP;
            free_cnt_d = RST_CNT;
            rr_d       = '0;
        end else begin
            if (fire) begin
                free_map_d[alloc_tag] = 1'b0;
                rr_d                  = winner_nxt;
            end
            if (rel_ok) free_map_d[bus.rel_tag_i] = 1'b1;
            free_cnt_d = free_cnt_q - (TAG_W+1)'(fire) + (TAG_W+1)'(rel_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map_q <= RST_MAP;
            free_cnt_q <= RST_CNT;
            rr_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            free_cnt_q <= free_cnt_d;
            rr_q       <= rr_d;
            err_q      <= err_d;
        end
    end

    assign bus.alloc_ready_o = alloc_ready;
    assign bus.alloc_tag_o   = alloc_tag;
    assign bus.empty_o       = empty;
    assign bus.free_cnt_o    = free_cnt_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_tag_free_list_arbiter.sv
// Directed bench for tag_free_list_arbiter: expected grants go into a scoreboard
// queue that a negedge monitor drains; status outputs are checked after each cycle.
module tb_tag_free_list_arbiter;
    import tag_free_list_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_free_list_arbiter_if #(.NUM_TAGS(16), .NUM_REQ(2)) bus();

    tag_free_list_arbiter #(
        .NUM_TAGS     (16),
        .NUM_REQ      (2),
        .NUM_RESERVED (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [1:0] rdy;
        tag_t       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    task automatic st(input string name, input int cnt, input logic emp, input logic err);
        chk({name, "_cnt"},   bus.free_cnt_o, cnt);
        chk({name, "_empty"}, bus.empty_o,    emp);
        chk({name, "_err"},   bus.err_o,      err);
    endtask

    task automatic idle();
        bus.alloc_valid_i = 2'b00;
        bus.rel_valid_i   = 1'b0;
        bus.rel_tag_i     = '0;
        bus.flush_i       = 1'b0;
    endtask

    // One clock of stimulus; er/et give the grant expected in this cycle (er=0: none).
    task automatic cyc(input logic [1:0] v, input logic rv, input int rt, input logic fl,
                       input logic [1:0] er, input int et);
        exp_t e;
        if (er != 2'b00) begin
            e.cyc = cur_cyc;
            e.rdy = er;
            e.tag = tag_t'(et);
            sb_q.push_back(e);
        end
        bus.alloc_valid_i = v;
        bus.rel_valid_i   = rv;
        bus.rel_tag_i     = tag_t'(rt);
        bus.flush_i       = fl;
        @(posedge clk);
        #1;
        cur_cyc++;
        idle();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.alloc_ready_o !== 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got ready %b tag %0d expected no grant (cycle %0d)",
                             bus.alloc_ready_o, bus.alloc_tag_o, cur_cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("grant_cycle", cur_cyc,           mon_e.cyc);
                    chk("grant_ready", bus.alloc_ready_o, mon_e.rdy);
                    chk("grant_tag",   bus.alloc_tag_o,   mon_e.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        st("reset", 15, 1'b0, 1'b0);
        chk("reset_tag",   bus.alloc_tag_o,   1);
        chk("reset_ready", bus.alloc_ready_o, 0);

        // requester 0 alone: tags 1,2,3
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 1); st("t1_a", 14, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 2); st("t1_b", 13, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 3); st("t1_c", 12, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 0, 1'b1, 2'b00, 0); st("t1_flush", 15, 1'b0, 1'b0);
        chk("t1_flush_tag", bus.alloc_tag_o, 1);

        // both requesters until the list is exhausted
        for (int i = 0; i < 15; i++)
            cyc(2'b11, 1'b0, 0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, i + 1);
        st("t2_full", 0, 1'b1, 1'b0);
        cyc(2'b11, 1'b0, 0, 1'b0, 2'b00, 0); st("t2_hold", 0, 1'b1, 1'b0);

        // release from empty: no grant in the release cycle
        cyc(2'b11, 1'b1, 7, 1'b0, 2'b00, 0); st("t3_rel", 1, 1'b0, 1'b0);
        chk("t3_tag", bus.alloc_tag_o, 7);
        cyc(2'b11, 1'b0, 0, 1'b0, 2'b10, 7); st("t3_regrant", 0, 1'b1, 1'b0);

        // same-cycle release of 3 and grant of 5
        cyc(2'b00, 1'b1, 5, 1'b0, 2'b00, 0); st("t4_rel5", 1, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 3, 1'b0, 2'b01, 5); st("t4_same", 1, 1'b0, 1'b0);
        chk("t4_tag", bus.alloc_tag_o, 3);
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 3); st("t4_after", 0, 1'b1, 1'b0);

        // illegal releases
        cyc(2'b00, 1'b1, 0, 1'b0, 2'b00, 0); st("t5_rel0", 0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #3;
        chk("async_rst_err", bus.err_o,      0);
        chk("async_rst_cnt", bus.free_cnt_o, 15);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        st("t5_after_rst", 15, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 9, 1'b0, 2'b00, 0); st("t5_dup9", 15, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 0, 1'b1, 2'b00, 0); st("t5_flush", 15, 1'b0, 1'b1);

        // flush beats allocation and release
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 1);
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 2);
        cyc(2'b01, 1'b0, 0, 1'b0, 2'b01, 3); st("t6_pre", 12, 1'b0, 1'b1);
        cyc(2'b11, 1'b1, 2, 1'b1, 2'b00, 0); st("t6_flush", 15, 1'b0, 1'b1);
        chk("t6_tag", bus.alloc_tag_o, 1);
        cyc(2'b11, 1'b0, 0, 1'b0, 2'b01, 1); st("t6_post", 14, 1'b0, 1'b1);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_free_list_arbiter.md
Name: tag_free_list_arbiter

Overview:
- Bitmap free list of NUM_TAGS physical tags (ROB / physical-register style), shared between NUM_REQ allocation requesters.
- Grants at most one allocation per cycle under round-robin arbitration.
- The allocated tag is the lowest-index free tag, found by one leading_zero_one_cnt instance on the free bitmap.
- Accepts one tag release per cycle from commit and a global flush from the recovery logic.

Parameters:
- NUM_TAGS, 16, number of tags; power of two, >= 2.
- NUM_REQ, 2, number of allocation requesters, 1..4.
- NUM_RESERVED, 1, tags 0..NUM_RESERVED-1 are permanently allocated; never granted, never released.
- TAG_W, $clog2(NUM_TAGS), tag width (derived, do not override).

Ports:
- clk, in, 1, clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- alloc_valid_i, in, NUM_REQ, per-requester allocation request.
- alloc_ready_o, out, NUM_REQ, per-requester grant; one-hot or zero.
- alloc_tag_o, out, TAG_W, tag being granted this cycle (shared by all requesters).
- rel_valid_i, in, 1, release strobe.
- rel_tag_i, in, TAG_W, tag to return.
- flush_i, in, 1, restore the free list to its reset contents.
- free_cnt_o, out, TAG_W+1, number of free tags (registered).
- empty_o, out, 1, no free tag (combinational from the bitmap).
- err_o, out, 1, sticky protocol-error flag.

Behaviour:
- State:
  - free_map[NUM_TAGS-1:0]: 1 = free.
  - rr_ptr: $clog2(NUM_REQ) bits, minimum 1.
  - free_cnt.
  - err.
- Reset (rst_n low, asynchronous):
  - free_map = all ones, except bits 0..NUM_RESERVED-1 = 0.
  - free_cnt = NUM_TAGS-NUM_RESERVED; rr_ptr = 0; err = 0.
  - Outputs: alloc_ready_o = 0; alloc_tag_o = NUM_RESERVED; empty_o = 0; free_cnt_o = NUM_TAGS-NUM_RESERVED; err_o = 0.
- Tag search:
  - leading_zero_one_cnt with DATA_WIDTH=NUM_TAGS, COUNT_ZERO=1, driven by free_map.
  - cnt = index of the lowest set bit, or NUM_TAGS when no bit is set.
  - empty_o = cnt MSB.
  - alloc_tag_o = cnt[TAG_W-1:0]. The value is don't-care when empty, but is driven, never X.
- Arbitration (combinational):
  - Search requesters starting at rr_ptr, in increasing index with wrap; the first valid one wins.
  - alloc_ready_o[w] = 1 only when a winner exists, !empty_o and !flush_i.
  - The ready of a requester depends on the valid inputs of all requesters. A requester must not make its valid depend on its ready.
- Allocation fire = valid & ready on the winner. At the next edge:
  - free_map[alloc_tag_o] <= 0.
  - rr_ptr <= winner+1, mod NUM_REQ.
  - No fire: rr_ptr holds.
- Latency: the tag is available in the same cycle as the grant. The bitmap update is visible one cycle later, so back-to-back grants return successive lowest free tags.
- Release, when rel_valid_i is high and flush_i is low:
  - rel_tag_i < NUM_RESERVED, or free_map[rel_tag_i] already 1: ignore the release and set err.
  - Otherwise free_map[rel_tag_i] <= 1 at the next edge.
- Same-cycle allocation and release:
  - Allocation uses the pre-release bitmap, so a released tag cannot be granted in its release cycle.
  - Both updates apply at the edge.
- free_cnt next value = free_cnt - alloc_fire + rel_accepted. Net zero when both occur.
  - Invariant: free_cnt equals popcount(free_map) at all times. The bench checks this; the RTL does not compute a popcount.
- Flush:
  - Has priority over allocation and release in the same cycle.
  - Forces ready low and ignores the release.
  - Next edge: free_map, free_cnt and rr_ptr return to their reset values. err is not cleared.
- Full allocation: once the last free tag is granted, empty_o = 1 and all readies are 0 the next cycle, until a release or flush.
- err is sticky; only rst_n clears it.

Decomposition:
- Shared package holds:
  - tag_t typedef (TAG_W bits).
  - The reset-mask function (NUM_TAGS, NUM_RESERVED -> bitmap).
  - The MAX_REQ=4 constant.
- One sub-module: the existing leading_zero_one_cnt, instantiated once with COUNT_ZERO=1.
- The round-robin pick stays inline; it is too small to justify a module.

Test Plan:
- After reset, requester 0 valid for 3 cycles -> grants tags 1, 2, 3 on consecutive cycles; free_cnt_o steps 15 -> 14 -> 13 -> 12.
- Both requesters valid every cycle from reset -> readies alternate 01, 10, 01, 10 with tags 1, 2, 3, 4; after 15 grants empty_o = 1, readies = 0, free_cnt_o = 0.
- From empty, release tag 7 with both requesters valid -> no grant in the release cycle; next cycle grants tag 7; free_cnt_o goes 0 -> 1 -> 0.
- Same-cycle release of tag 3 and grant of tag 5 -> free_cnt_o unchanged; next grant returns tag 3.
- Release tag 0, then re-release the already-free tag 9 -> both ignored; err_o = 1 and stays 1 through a following flush.
- Flush asserted with requester valid and release of tag 2 -> ready = 0 and release ignored; next cycle free_cnt_o = 15, alloc_tag_o = 1, rr_ptr = 0.
